prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer_pkg.sv | 13 +
 rtl/timer_prescaler.sv | 27 ++
 rtl/prog_timer.sv | 89 ++++++++
 tb/tb_prog_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// Shared encodings for the programmable timer: FSM states and counting modes.
package prog_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Divides running cycles into ticks: one tick every presc+1 cycles while run is high.
module timer_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    // Using >= lets a presc reduced below the current count fire at once instead of stalling.
    assign tick = run && (pcnt >= presc);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
        if (rst || clr) begin
            pcnt <= '0;
        end else if (run) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Programmable timer: compare register, up-counter, sticky irq and IDLE/RUN/DONE FSM.
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               load_we,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc,
    input  logic               irq_clr,
    output logic [WIDTH-1:0]   timer,
    output logic               running,
    output logic               irq
);

    state_t           state;
    logic [WIDTH-1:0] cmp;
    logic             tick;

    // Prescaler only advances in RUN with en high; any other state or a load clears it.
    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_we || (state != RUN)),
        .run   ((state == RUN) && en),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: cmp is a control register, not a memory, so it gets a defined all-ones reset value.
            state   <= IDLE;
            timer   <= '0;
            cmp     <= '1;
            irq     <= 1'b0;
            running <= 1'b0;
        end else begin
            // Clear first so a terminal-count set later in this block takes priority.
            if (irq_clr) irq <= 1'b0;

            if (load_we) begin
                cmp     <= load_val;
                timer   <= '0;
                state   <= IDLE;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= '0;
                        if (en) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (timer == cmp) begin
                                irq <= 1'b1;
                                if (mode == MODE_ONESHOT) begin
                                    state   <= DONE;
                                    running <= 1'b0;
                                end else begin
                                    timer <= '0;
                                end
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    DONE: ;
                    default: begin
                        state   <= IDLE;
                        timer   <= '0;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_timer.sv
// Directed and randomized checks of prog_timer against a cycle-level behavioural model.
module tb_prog_timer;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 4;
    localparam int MAXV    = (1 << WIDTH) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               mode = 1'b0;
    logic               load_we = 1'b0;
    logic [WIDTH-1:0]   load_val = '0;
    logic [PRESC_W-1:0] presc = '0;
    logic               irq_clr = 1'b0;
    logic [WIDTH-1:0]   timer;
    logic               running;
    logic               irq;

    int checks = 0;
    int errors = 0;

    prog_timer #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .load_we  (load_we),
        .load_val (load_val),
        .presc    (presc),
        .irq_clr  (irq_clr),
        .timer    (timer),
        .running  (running),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: phase of the timer plus plain integer counters.
    typedef enum int {M_IDLE, M_RUN, M_DONE} m_phase_t;
    m_phase_t m_phase = M_IDLE;
    int       m_timer = 0;
    int       m_cmp   = MAXV;
    int       m_pcnt  = 0;
    bit       m_irq   = 1'b0;

    task automatic model_update();
        bit next_irq;
        if (rst) begin
            m_phase = M_IDLE;
            m_timer = 0;
            m_cmp   = MAXV;
            m_pcnt  = 0;
            m_irq   = 1'b0;
            return;
        end
        next_irq = irq_clr ? 1'b0 : m_irq;
        if (load_we) begin
            m_cmp   = int'(load_val);
            m_timer = 0;
            m_pcnt  = 0;
            m_phase = M_IDLE;
        end else if (m_phase == M_IDLE) begin
            if (en) m_phase = M_RUN;
        end else if (m_phase == M_RUN && en) begin
            if (m_pcnt >= int'(presc)) begin
                m_pcnt = 0;
                if (m_timer == m_cmp) begin
                    next_irq = 1'b1;
                    if (mode) m_phase = M_DONE;
                    else      m_timer = 0;
                end else begin
                    m_timer = (m_timer + 1) % (MAXV + 1);
                end
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
        m_irq = next_irq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance model with the pre-edge inputs, then compare all outputs.
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".timer"},   32'(timer),   32'(m_timer));
        check({tag, ".running"}, 32'(running), 32'(m_phase == M_RUN));
        check({tag, ".irq"},     32'(irq),     32'(m_irq));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Free-running wrap counter after reset with no load.
        rst = 1'b1;
        step("reset");
        check("reset_timer", 32'(timer), 0);
        check("reset_running", 32'(running), 0);
        check("reset_irq", 32'(irq), 0);
        rst = 1'b0; en = 1'b1; mode = 1'b0; presc = '0;
        step("wrap_start");
        check("wrap_start_running", 32'(running), 1);
        for (int j = 1; j <= 256; j++) begin
            step("wrap");
            if (j == 255) begin
                check("wrap_top_timer", 32'(timer), 255);
                check("wrap_top_irq", 32'(irq), 0);
            end
        end
        check("wrap_zero_timer", 32'(timer), 0);
        check("wrap_irq_set", 32'(irq), 1);

        // One-shot to 5, then en ignored in DONE.
        load_we = 1'b1; load_val = 8'd5; irq_clr = 1'b1; en = 1'b0;
        step("os_load");
        load_we = 1'b0; irq_clr = 1'b0; mode = 1'b1; en = 1'b1;
        step("os_start");
        for (int j = 1; j <= 5; j++) begin
            step("os_count");
            check("os_count_timer", 32'(timer), 32'(j));
        end
        step("os_done");
        check("os_done_timer", 32'(timer), 5);
        check("os_done_running", 32'(running), 0);
        check("os_done_irq", 32'(irq), 1);
        for (int j = 0; j < 4; j++) begin
            en = j[0];
            step("os_en_toggle");
            check("os_hold_timer", 32'(timer), 5);
        end

        // Periodic with cmp=3 and presc=2.
        load_we = 1'b1; load_val = 8'd3; irq_clr = 1'b1; mode = 1'b0; presc = 4'd2;
        step("ps_load");
        load_we = 1'b0; irq_clr = 1'b0; en = 1'b1;
        step("ps_start");
        for (int s = 1; s <= 12; s++) begin
            step("ps_count");
            if (s < 12) check("ps_timer", 32'(timer), 32'(s / 3));
        end
        check("ps_wrap_timer", 32'(timer), 0);
        check("ps_wrap_irq", 32'(irq), 1);

        // irq_clr racing a terminal tick.
        presc = '0; irq_clr = 1'b1;
        step("clr_first");
        check("clr_first_irq", 32'(irq), 0);
        irq_clr = 1'b0;
        step("clr_cnt");
        step("clr_cnt");
        check("clr_pre_timer", 32'(timer), 3);
        irq_clr = 1'b1;
        step("clr_race");
        check("clr_race_irq", 32'(irq), 1);
        step("clr_next");
        check("clr_next_irq", 32'(irq), 0);
        irq_clr = 1'b0;

        // Freeze at timer=2, resume to 3, then load while running at 4.
        load_we = 1'b1; load_val = 8'd7;
        step("frz_load");
        load_we = 1'b0;
        step("frz_start");
        step("frz_cnt");
        step("frz_cnt");
        en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step("frz_hold");
            check("frz_hold_timer", 32'(timer), 2);
            check("frz_hold_running", 32'(running), 1);
        end
        en = 1'b1;
        step("frz_resume");
        check("frz_resume_timer", 32'(timer), 3);
        step("frz_cnt");
        check("ld_pre_timer", 32'(timer), 4);
        load_we = 1'b1; load_val = 8'd7;
        step("ld_run");
        check("ld_run_timer", 32'(timer), 0);
        check("ld_run_running", 32'(running), 0);

        // Reach DONE, reset there, then confirm cmp returned to all-ones.
        load_we = 1'b0; mode = 1'b1;
        for (int j = 0; j < 9; j++) step("rd_run");
        check("rd_done_running", 32'(running), 0);
        check("rd_done_timer", 32'(timer), 7);
        rst = 1'b1;
        step("rd_reset");
        check("rd_reset_timer", 32'(timer), 0);
        check("rd_reset_irq", 32'(irq), 0);
        check("rd_reset_running", 32'(running), 0);
        rst = 1'b0;
        for (int j = 0; j < 257; j++) step("rd_cmp_max");
        check("rd_cmp_max_timer", 32'(timer), 255);
        check("rd_cmp_max_running", 32'(running), 0);

        // cmp=0 periodic: timer pinned at 0, irq set every tick despite irq_clr.
        load_we = 1'b1; load_val = '0; mode = 1'b0;
        step("z_load");
        load_we = 1'b0;
        step("z_start");
        irq_clr = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step("z_tick");
            check("z_timer", 32'(timer), 0);
            check("z_irq", 32'(irq), 1);
        end
        irq_clr = 1'b0;

        // Randomized traffic against the model.
        for (int j = 0; j < 3000; j++) begin
            rst      = ($urandom_range(0, 127) == 0);
            load_we  = ($urandom_range(0, 31) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 12));
            en       = ($urandom_range(0, 9) < 8);
            mode     = ($urandom_range(0, 15) == 0);
            irq_clr  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) presc = PRESC_W'($urandom_range(0, 3));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
